// File: rtl/frag_fifo_if.sv
// Bus bundle between a t-pipe fragment FIFO and its producer/consumer.
interface frag_fifo_if #(
    parameter int unsigned DATA_WIDTH                  = 32,
    parameter int unsigned FIFO_MAX_FRAGMENTS          = 4,
    parameter int unsigned LOCAL_VERTEX_MEM_ADDR_WIDTH = 4
);
    localparam int unsigned DEPTH = FIFO_MAX_FRAGMENTS * (2 ** LOCAL_VERTEX_MEM_ADDR_WIDTH);
    localparam int unsigned CW    = $clog2(DEPTH + 1);
    localparam int unsigned FW    = $clog2(DEPTH + 1);

    logic                                   en;
    logic [DATA_WIDTH-1:0]                  wr_data;
    logic                                   wr_en;
    logic                                   rd_en;
    logic                                   clear_err;
    logic [LOCAL_VERTEX_MEM_ADDR_WIDTH-1:0] vertexSize;
    logic [DATA_WIDTH-1:0]                  rd_data;
    logic                                   full;
    logic                                   empty;
    logic                                   threshold;
    logic                                   overflow;
    logic                                   underflow;
    logic [CW-1:0]                          word_count;
    logic [FW-1:0]                          frag_count;

    modport master (
        output en, wr_data, wr_en, rd_en, clear_err, vertexSize,
        input  rd_data, full, empty, threshold, overflow, underflow, word_count, frag_count
    );

    modport slave (
        input  en, wr_data, wr_en, rd_en, clear_err, vertexSize,
        output rd_data, full, empty, threshold, overflow, underflow, word_count, frag_count
    );
endinterface

// File: rtl/frag_fifo.sv
// FWFT circular word buffer that counts complete fragments of vertexSize+1 words.
module frag_fifo #(
    parameter int unsigned DATA_WIDTH                  = 32,
    parameter int unsigned FIFO_MAX_FRAGMENTS          = 4,
    parameter int unsigned LOCAL_VERTEX_MEM_ADDR_WIDTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    frag_fifo_if.slave bus
);
    localparam int unsigned VW    = LOCAL_VERTEX_MEM_ADDR_WIDTH;
    localparam int unsigned DEPTH = FIFO_MAX_FRAGMENTS * (2 ** VW);
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CW    = $clog2(DEPTH + 1);
    localparam int unsigned FW    = $clog2(DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [VW-1:0] wi_q, wi_d;
    logic [VW-1:0] ri_q, ri_d;
    logic [CW-1:0] word_count_q, word_count_d;
    logic [FW-1:0] frag_count_q, frag_count_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;

    logic push_c, pop_c, full_c, empty_c, complete_c, retire_c;

    // Accept/reject decisions and next-state for pointers, indices, counts and sticky errors.
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        wi_d         = wi_q;
        ri_d         = ri_q;
        word_count_d = word_count_q;
        frag_count_d = frag_count_q;
        overflow_d   = overflow_q;
        underflow_d  = underflow_q;

        full_c     = (word_count_q == CW'(DEPTH));
        empty_c    = (word_count_q == '0);
        pop_c      = bus.en & bus.rd_en & ~empty_c;
        push_c     = bus.en & bus.wr_en & (~full_c | pop_c);
        complete_c = push_c & (wi_q == bus.vertexSize);
        retire_c   = pop_c & (ri_q == bus.vertexSize);

        if (push_c) begin
            wr_ptr_d = (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
            wi_d     = complete_c ? '0 : wi_q + VW'(1);
        end
        if (pop_c) begin
            rd_ptr_d = (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1);
            ri_d     = retire_c ? '0 : ri_q + VW'(1);
        end

        case ({push_c, pop_c})
            2'b10:   word_count_d = word_count_q + CW'(1);
            2'b01:   word_count_d = word_count_q - CW'(1);
            default: word_count_d = word_count_q;
        endcase

        case ({complete_c, retire_c})
            2'b10:   frag_count_d = frag_count_q + FW'(1);
            2'b01:   frag_count_d = frag_count_q - FW'(1);
            default: frag_count_d = frag_count_q;
        endcase

        // A fresh error outranks clear_err in the same cycle.
        if (bus.en) begin
            overflow_d  = (overflow_q & ~bus.clear_err) | (bus.wr_en & ~push_c);
            underflow_d = (underflow_q & ~bus.clear_err) | (bus.rd_en & ~pop_c);
        end
    end

    // Control state; en=0 leaves every _d equal to its _q.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            wi_q         <= '0;
            ri_q         <= '0;
            word_count_q <= '0;
            frag_count_q <= '0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            wi_q         <= wi_d;
            ri_q         <= ri_d;
            word_count_q <= word_count_d;
            frag_count_q <= frag_count_d;
            overflow_q   <= overflow_d;
            underflow_q  <= underflow_d;
        end
    end

    // Storage array; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_q[wr_ptr_q] <= bus.wr_data;
        end
    end

    assign bus.rd_data    = mem_q[rd_ptr_q];
    assign bus.full       = full_c;
    assign bus.empty      = empty_c;
    assign bus.threshold  = (frag_count_q != '0);
    assign bus.overflow   = overflow_q;
    assign bus.underflow  = underflow_q;
    assign bus.word_count = word_count_q;
    assign bus.frag_count = frag_count_q;
endmodule

// File: doc/frag_fifo.md
# frag_fifo

Per-triangle-pipe fragment buffer between a rasteriser t-pipe and the fragment write arbiter. It accepts fragment words from the t-pipe and holds them in a first-word-fall-through circular buffer. It tracks how many complete fragments (vertexSize+1 words each) are stored and raises `threshold` whenever at least one whole fragment can be drained. One instance exists per t-pipe; its read-side flags and data feed the arbiter's `frag_fifo_*` input vectors.

## Interface
- `DATA_WIDTH`, 32: width of one fragment word.
- `FIFO_MAX_FRAGMENTS`, 4: capacity in maximum-size fragments.
- `LOCAL_VERTEX_MEM_ADDR_WIDTH`, 4: width of `vertexSize`.
- Derived `DEPTH` = FIFO_MAX_FRAGMENTS * 2^LOCAL_VERTEX_MEM_ADDR_WIDTH words (64 by default); `CW` = clog2(DEPTH+1); `FW` = clog2(DEPTH+1).
- Clocking and reset: one clock; reset is asynchronous and active-high.
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `en`  in  1  global enable; when low, state is frozen and `wr_en`/`rd_en` are ignored.
- `wr_data`  in  DATA_WIDTH  fragment word from the t-pipe.
- `wr_en`  in  1  push request.
- `rd_en`  in  1  pop request from the arbiter.
- `rd_data`  out  DATA_WIDTH  head word, valid whenever `empty`=0.
- `full`  out  1  word count == DEPTH.
- `empty`  out  1  word count == 0.
- `threshold`  out  1  `frag_count` != 0.
- `overflow`  out  1  sticky: a push was rejected.
- `underflow`  out  1  sticky: a pop was rejected.
- `clear_err`  in  1  synchronous clear of `overflow`/`underflow`.
- `word_count`  out  CW  number of stored words.
- `frag_count`  out  FW  number of complete fragments stored and not yet fully popped.
- `vertexSize`  in  LOCAL_VERTEX_MEM_ADDR_WIDTH  words per fragment minus one. Must be stable from reset until the FIFO is empty again.

## Operation
- Storage: DEPTH-entry register array with `wr_ptr`/`rd_ptr` of clog2(DEPTH) bits. Pointers wrap from DEPTH-1 to 0.
- `rd_data` = mem[`rd_ptr`] combinationally (FWFT). When `empty`, its value is don't-care.
- Push accepted when `en` && `wr_en` && (!`full` || pop accepted in the same cycle).
- Pop accepted when `en` && `rd_en` && !`empty`. A simultaneous push into an empty FIFO does not make that pop valid.
- Rejected push sets `overflow`. Rejected pop sets `underflow`. Data, pointers and counts are unchanged by a rejected request.
- `clear_err` clears both flags. A new error in the same cycle wins, so the flag remains set.
- `word_count` changes by +1 for a push alone, -1 for a pop alone, and 0 for both or neither.
- Write-side word index `wi` (LOCAL_VERTEX_MEM_ADDR_WIDTH bits):
  - increments on each accepted push;
  - on a push with `wi`==`vertexSize`, it returns to 0 and a fragment is completed.
- Read-side word index `ri` behaves the same way on accepted pops; a pop with `ri`==`vertexSize` retires a fragment.
- `frag_count` changes by +1 on a completion alone, -1 on a retire alone, and 0 for both.
- A partially written fragment never asserts `threshold`.
- vertexSize==0 is a legal setting: every word is a whole fragment.

## Timing
- Reset values:
  - `word_count`=0, `frag_count`=0, `empty`=1, `full`=0, `threshold`=0, `overflow`=0, `underflow`=0;
  - pointers, `wi` and `ri` = 0;
  - `rd_data` is don't-care and array contents are not reset.
- Flags and counts are registered or decoded from registered state, so they reflect a push or pop on the cycle after the edge.
- Latency: a word pushed at edge N appears on `rd_data` after edge N when the FIFO was empty.
- Fragment latency: `threshold` rises in the cycle after the edge that accepts the last word of a fragment.
- Arbiter handshake: the arbiter samples `rd_data` on the same edge where it holds `rd_en`=1. That edge pops the word.
- Reset asserted mid-fragment discards all contents and partial indices immediately, without waiting for a clock edge.
- `en`=0 in mid-fragment: `wi`/`ri` hold their values, and the stream resumes from the same position.

## Test plan
- Reset then idle:
  - `empty`=1, `threshold`=0, both counts 0;
  - `rd_en` pulse while empty -> `underflow`=1, counts unchanged.
- vertexSize=3, push words 0xA0..0xA2:
  - `word_count`=3, `threshold`=0;
  - push 0xA3 -> next cycle `threshold`=1, `frag_count`=1, `rd_data`=0xA0.
- vertexSize=3, two fragments stored:
  - pop 4 words back-to-back -> `rd_data` sequence 0xA0..0xA3, then `frag_count`=1 and `threshold` still 1;
  - pop 4 more -> `empty`=1, `threshold`=0.
- Fill 64 words (vertexSize=15):
  - `full`=1, `frag_count`=4;
  - extra push -> `overflow`=1, data intact;
  - push+pop together while full -> accepted, `word_count` stays 64, pointers wrap correctly.
- Simultaneous completion and retire (vertexSize=1):
  - last write word and last read word on the same edge -> `frag_count` unchanged;
  - push into empty with `rd_en`=1 -> `underflow`=1, `word_count`=1.
- Mid-fragment reset:
  - push 2 of 4 words, assert `reset` asynchronously -> all outputs return to reset values before the next edge;
  - a full fragment pushed afterwards raises `threshold` normally.
